// File: rtl/dcache_wb_if.sv
// dcache_wb_if: processor-side and memory-side buses of the write-back data cache
interface dcache_wb_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back write-allocate cache, 8 lines x 4 words x 32 bits
module dcache_wb (
  input logic       clk,
  input logic       rst,
  dcache_wb_if.slave bus
);
  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;
  state_t state, state_nx;
  logic [7:0]   valid, dirty;
  logic [24:0]  tags  [8];
  logic [127:0] lines [8];
  logic [2:0]   idx;
  logic [1:0]   off;
  logic [24:0]  ptag;
  logic         req, hit;
  assign idx  = bus.proc_addr[4:2];
  assign off  = bus.proc_addr[1:0];
  assign ptag = bus.proc_addr[29:5];
  assign req  = bus.proc_read | bus.proc_write;
  assign hit  = valid[idx] && tags[idx] == ptag;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= COMPARE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      COMPARE:   state_nx = (req && !hit) ? ((valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE) : COMPARE;
      WRITEBACK: state_nx = bus.mem_ready ? ALLOCATE : WRITEBACK;
      ALLOCATE:  state_nx = bus.mem_ready ? COMPARE : ALLOCATE;
      default:   state_nx = COMPARE;
    endcase
  end
  always_comb begin
    bus.proc_stall = (state == COMPARE) ? (req && !hit) : 1'b1;
    bus.mem_write  = state == WRITEBACK;
    bus.mem_read   = state == ALLOCATE;
    bus.mem_addr   = (state == WRITEBACK) ? {tags[idx], idx} :
                     (state == ALLOCATE)  ? bus.proc_addr[29:2] : 28'd0;
    bus.mem_wdata  = (state == WRITEBACK) ? lines[idx] : 128'd0;
    bus.proc_rdata = lines[idx][{off, 5'b0} +: 32];
  end
  // a write miss lands here only after the fill, so the store always goes through the hit path
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= '0;
      dirty <= '0;
      for (int i = 0; i < 8; i++) begin
        tags[i]  <= '0;
        lines[i] <= '0;
      end
    end else if (state == ALLOCATE && bus.mem_ready) begin
      lines[idx] <= bus.mem_rdata;
      tags[idx]  <= ptag;
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (state == COMPARE && bus.proc_write && hit) begin
      lines[idx][{off, 5'b0} +: 32] <= bus.proc_wdata;
      dirty[idx] <= 1'b1;
    end
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed vector table plus reset-during-fill sequence against a latency-programmable memory model
module tb_dcache_wb;
  logic clk = 0;
  logic rst = 1;
  int tests = 0;
  int fails = 0;
  dcache_wb_if bus ();
  dcache_wb dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [127:0] mm [logic [27:0]];
  int lat = 3;
  int cnt = 0;
  int rd_cnt = 0, wr_cnt = 0;
  logic [27:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;

  always @(negedge clk) begin
    if (bus.mem_ready) begin
      bus.mem_ready = 0;
      cnt = 0;
    end
    if (!(bus.mem_read || bus.mem_write)) cnt = 0;
    else begin
      cnt++;
      if (cnt == lat) begin
        bus.mem_ready = 1;
        if (bus.mem_write) begin
          mm[bus.mem_addr] = bus.mem_wdata;
          wr_cnt++;
          last_wr_addr = bus.mem_addr;
          last_wr_data = bus.mem_wdata;
        end else begin
          bus.mem_rdata = mm.exists(bus.mem_addr) ? mm[bus.mem_addr] :
            {bus.mem_addr, 4'h3, bus.mem_addr, 4'h2, bus.mem_addr, 4'h1, bus.mem_addr, 4'h0};
          rd_cnt++;
          last_rd_addr = bus.mem_addr;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rdata);
    bus.proc_read = rd;
    bus.proc_write = wr;
    bus.proc_addr = a;
    bus.proc_wdata = wd;
    stalls = 0;
    @(negedge clk);
    while (bus.proc_stall && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    rdata = bus.proc_rdata;
    @(posedge clk);
    #1;
    bus.proc_read = 0;
    bus.proc_write = 0;
  endtask

  typedef struct {
    logic rd, wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    int lat;
    int exp_stalls;
    logic rd_chk;
    logic [31:0] exp_rdata;
    int rd_delta, wr_delta;
    logic [27:0] exp_rd_addr, exp_wr_addr;
    logic [31:0] exp_wr_w1;
  } vec_t;

  function automatic vec_t v(logic rd, logic wr, logic [29:0] a, logic [31:0] wd, int l, int st,
                             logic rc, logic [31:0] er, int rdd, int wrd,
                             logic [27:0] ra, logic [27:0] wa, logic [31:0] w1);
    vec_t x;
    x.rd = rd; x.wr = wr; x.addr = a; x.wdata = wd; x.lat = l; x.exp_stalls = st;
    x.rd_chk = rc; x.exp_rdata = er; x.rd_delta = rdd; x.wr_delta = wrd;
    x.exp_rd_addr = ra; x.exp_wr_addr = wa; x.exp_wr_w1 = w1;
    return x;
  endfunction

  vec_t vecs [11];

  initial begin
    int st, r0, w0;
    logic [31:0] rdv;
    vecs[0]  = v(1, 0, 30'h05, 0,            3, 4, 1, 32'h22,       1, 0, 28'h1, 0,     0);
    vecs[1]  = v(0, 1, 30'h05, 32'hDEADBEEF, 3, 0, 0, 0,            0, 0, 0,     0,     0);
    vecs[2]  = v(1, 0, 30'h05, 0,            3, 0, 1, 32'hDEADBEEF, 0, 0, 0,     0,     0);
    vecs[3]  = v(1, 0, 30'h25, 0,            3, 7, 1, 32'h91,       1, 1, 28'h9, 28'h1, 32'hDEADBEEF);
    vecs[4]  = v(0, 1, 30'h0A, 32'hCAFEF00D, 3, 4, 0, 0,            1, 0, 28'h2, 0,     0);
    vecs[5]  = v(1, 0, 30'h0A, 0,            3, 0, 1, 32'hCAFEF00D, 0, 0, 0,     0,     0);
    vecs[6]  = v(1, 0, 30'h0B, 0,            3, 0, 1, 32'h23,       0, 0, 0,     0,     0);
    vecs[7]  = v(1, 1, 30'h0B, 32'h12345678, 3, 0, 0, 0,            0, 0, 0,     0,     0);
    vecs[8]  = v(1, 0, 30'h0B, 0,            3, 0, 1, 32'h12345678, 0, 0, 0,     0,     0);
    vecs[9]  = v(1, 0, 30'h2A, 0,            3, 7, 1, 32'hA2,       1, 1, 28'hA, 28'h2, 32'h21);
    vecs[10] = v(1, 0, 30'h0A, 0,            1, 2, 1, 32'hCAFEF00D, 1, 0, 28'h2, 0,     0);
    mm[28'h1] = {32'h44, 32'h33, 32'h22, 32'h11};
    bus.proc_read = 0; bus.proc_write = 0; bus.proc_addr = 0; bus.proc_wdata = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_stall", bus.proc_stall, 0);
    chk("reset_mem_read", bus.mem_read, 0);
    chk("reset_mem_write", bus.mem_write, 0);
    chk("reset_mem_addr", bus.mem_addr, 0);
    chk("reset_mem_wdata", bus.mem_wdata, 0);
    chk("reset_rdata", bus.proc_rdata, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      lat = vecs[i].lat;
      r0 = rd_cnt;
      w0 = wr_cnt;
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, rdv);
      chk($sformatf("v%0d_stalls", i), st, vecs[i].exp_stalls);
      if (vecs[i].rd_chk) chk($sformatf("v%0d_rdata", i), rdv, vecs[i].exp_rdata);
      chk($sformatf("v%0d_fills", i), rd_cnt - r0, vecs[i].rd_delta);
      chk($sformatf("v%0d_writebacks", i), wr_cnt - w0, vecs[i].wr_delta);
      if (vecs[i].rd_delta > 0) chk($sformatf("v%0d_fill_addr", i), last_rd_addr, vecs[i].exp_rd_addr);
      if (vecs[i].wr_delta > 0) begin
        chk($sformatf("v%0d_wb_addr", i), last_wr_addr, vecs[i].exp_wr_addr);
        chk($sformatf("v%0d_wb_word1", i), last_wr_data[63:32], vecs[i].exp_wr_w1);
      end
    end
    // reset while the fill is outstanding
    lat = 3;
    r0 = rd_cnt;
    bus.proc_read = 1;
    bus.proc_addr = 30'h45;
    @(negedge clk);
    chk("rst_seq_miss_stall", bus.proc_stall, 1);
    @(negedge clk);
    chk("rst_seq_alloc_read", bus.mem_read, 1);
    chk("rst_seq_alloc_addr", bus.mem_addr, 28'h11);
    rst = 1;
    #1;
    chk("rst_seq_read_dropped", bus.mem_read, 0);
    chk("rst_seq_addr_dropped", bus.mem_addr, 0);
    bus.proc_read = 0;
    @(posedge clk);
    #1 rst = 0;
    chk("rst_seq_no_fill", rd_cnt - r0, 0);
    access(1, 0, 30'h45, 0, st, rdv);
    chk("rst_seq_remiss_stalls", st, 4);
    chk("rst_seq_remiss_rdata", rdv, 32'h111);
    access(1, 0, 30'h05, 0, st, rdv);
    chk("rst_seq_cold_stalls", st, 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
